// File: rtl/eprisc_io_bus_master.sv
// CPU-side initiator for the epRISC I/O controller byte bus: shifts a 32-bit command out
// low byte first on MOSI, gathers four MISO bytes, and synchronizes the controller interrupt.
module eprisc_io_bus_master #(
  parameter int unsigned CLKDIV = 2,
  parameter logic [1:0]  SELECT = 2'h1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iWrite,
  input  logic [14:0] iAddr,
  input  logic [15:0] iData,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oReadData,
  output logic        oInterrupt,
  output logic        oBusClock,
  output logic [1:0]  oBusSelect,
  output logic [7:0]  oBusMOSI,
  input  logic [7:0]  iBusMISO,
  input  logic        iBusInterrupt
);

  typedef enum logic [2:0] {
    StResync, StIdle, StSetup, StHigh, StLow, StFinish
  } state_e;

  localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  rise_q, rise_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] resp_q, resp_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bclk_q, bclk_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  mosi_q, mosi_d;
  logic        irq_meta_q, irq_q;

  logic       tick;
  logic [1:0] tx_idx;
  logic [1:0] rx_idx;

  assign tick   = (div_q == DivLast);
  assign tx_idx = rise_q[1:0];
  // Falling edge after rise k stores response byte k-1; rise 4 wraps to index 3.
  assign rx_idx = rise_q[1:0] - 2'd1;

  always_comb begin
    state_d = state_q;
    div_d   = 8'd0;
    rise_d  = rise_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    bclk_d  = bclk_q;
    sel_d   = sel_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      StResync: begin
        // One deselected low/high/low pulse walks the controller pipeline back to Load.
        div_d = tick ? 8'd0 : div_q + 8'd1;
        if (tick) begin
          case (rise_q)
            3'd0: begin
              bclk_d = 1'b1;
              rise_d = 3'd1;
            end
            3'd1: begin
              bclk_d = 1'b0;
              rise_d = 3'd2;
            end
            default: begin
              rise_d  = 3'd0;
              state_d = StIdle;
            end
          endcase
        end
      end
      StIdle, StFinish: begin
        state_d = StIdle;
        // busy_q still high in the first idle cycle after resync blocks an early accept.
        if (iStart && !busy_q) begin
          cmd_d   = {iWrite, iAddr, iData};
          sel_d   = SELECT;
          bclk_d  = 1'b0;
          rise_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = StSetup;
        end else begin
          busy_d = 1'b0;
        end
      end
      StSetup, StLow: begin
        div_d = tick ? 8'd0 : div_q + 8'd1;
        if (tick) begin
          if (rise_q == 3'd6) begin
            sel_d   = 2'h0;
            mosi_d  = 8'h00;
            done_d  = 1'b1;
            rdata_d = resp_q;
            busy_d  = 1'b0;
            state_d = StFinish;
          end else begin
            bclk_d  = 1'b1;
            rise_d  = rise_q + 3'd1;
            mosi_d  = rise_q[2] ? 8'h00 : cmd_q[{tx_idx, 3'b000} +: 8];
            state_d = StHigh;
          end
        end
      end
      StHigh: begin
        div_d = tick ? 8'd0 : div_q + 8'd1;
        if (tick) begin
          bclk_d  = 1'b0;
          state_d = StLow;
          if (rise_q >= 3'd1 && rise_q <= 3'd4) begin
            resp_d[{rx_idx, 3'b000} +: 8] = iBusMISO;
          end
        end
      end
      default: state_d = StResync;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= StResync;
      div_q      <= 8'd0;
      rise_q     <= 3'd0;
      cmd_q      <= 32'h0;
      resp_q     <= 32'h0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      rdata_q    <= 32'h0;
      bclk_q     <= 1'b0;
      sel_q      <= 2'h0;
      mosi_q     <= 8'h00;
      irq_meta_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      rise_q     <= rise_d;
      cmd_q      <= cmd_d;
      resp_q     <= resp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      bclk_q     <= bclk_d;
      sel_q      <= sel_d;
      mosi_q     <= mosi_d;
      irq_meta_q <= iBusInterrupt;
      irq_q      <= irq_meta_q;
    end
  end

  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oReadData  = rdata_q;
  assign oInterrupt = irq_q;
  assign oBusClock  = bclk_q;
  assign oBusSelect = sel_q;
  assign oBusMOSI   = mosi_q;

endmodule

// File: tb/tb_eprisc_io_bus_master.sv
// Directed bench for eprisc_io_bus_master: behavioural controller model on the bus plus a
// scoreboard of expected responses and completion latencies.
module tb_eprisc_io_bus_master;

  localparam logic [1:0] Sel = 2'h1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        irq_i;

  logic        start1, write1;
  logic [14:0] addr1;
  logic [15:0] data1;
  logic        busy1, done1, irq_o1, bclk1;
  logic [31:0] rd1;
  logic [1:0]  sel1;
  logic [7:0]  mosi1;
  logic [7:0]  miso1 = 8'h00;

  logic        start2, write2;
  logic [14:0] addr2;
  logic [15:0] data2;
  logic        busy2, done2, irq_o2, bclk2;
  logic [31:0] rd2;
  logic [1:0]  sel2;
  logic [7:0]  mosi2;
  logic [7:0]  miso2;

  eprisc_io_bus_master #(.CLKDIV(2), .SELECT(Sel)) u_dut1 (
    .iClk(clk), .iRst(rst), .iStart(start1), .iWrite(write1), .iAddr(addr1), .iData(data1),
    .oBusy(busy1), .oDone(done1), .oReadData(rd1), .oInterrupt(irq_o1), .oBusClock(bclk1),
    .oBusSelect(sel1), .oBusMOSI(mosi1), .iBusMISO(miso1), .iBusInterrupt(irq_i)
  );

  eprisc_io_bus_master #(.CLKDIV(1), .SELECT(Sel)) u_dut2 (
    .iClk(clk), .iRst(rst), .iStart(start2), .iWrite(write2), .iAddr(addr2), .iData(data2),
    .oBusy(busy2), .oDone(done2), .oReadData(rd2), .oInterrupt(irq_o2), .oBusClock(bclk2),
    .oBusSelect(sel2), .oBusMOSI(mosi2), .iBusMISO(miso2), .iBusInterrupt(irq_i)
  );

  // Controller model: MISO returns the word at the address latched by the previous command.
  logic [31:0] mem [256];
  logic [7:0]  m_prev = 8'h00;
  int          m_k = 0;
  logic        m_clk_prev = 1'b0;
  logic [31:0] m_cmd = 32'h0;
  logic [31:0] m_resp = 32'h0;
  logic [7:0]  mosi_log [6];

  always @(negedge clk) begin
    m_clk_prev <= bclk1;
    if (sel1 == 2'h0) begin
      m_k <= 0;
    end else if (bclk1 && !m_clk_prev) begin
      m_k <= m_k + 1;
      if (m_k < 6) mosi_log[m_k] <= mosi1;
      if (m_k == 0) begin
        m_resp <= mem[m_prev];
        miso1  <= mem[m_prev][7:0];
      end else if (m_k < 4) begin
        miso1 <= m_resp[8*m_k +: 8];
      end
      if (m_k < 4) m_cmd[8*m_k +: 8] <= mosi1;
      if (m_k == 3) m_prev <= m_cmd[23:16];
      if (m_k == 4 && m_cmd[31]) mem[m_cmd[23:16]] <= m_cmd;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] rd, input int lat);
    exp_t x;
    x.tag = tag;
    x.rd  = rd;
    x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic drive1(input logic w, input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    start1 = 1'b1;
    write1 = w;
    addr1  = a;
    data1  = d;
  endtask

  // Entered at the negedge of cycle n0-1; watches for oDone and scores it against the queue.
  task automatic wait_done(input bit u2, input int n0, input int exp_rise);
    int   n;
    bit   seen;
    int   first_rise;
    int   low_busy;
    exp_t e;
    seen = 1'b0;
    first_rise = -1;
    low_busy = 0;
    n = n0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (u2 ? done2 : done1) begin
        seen = 1'b1;
      end else begin
        if (first_rise < 0 && (u2 ? bclk2 : bclk1)) first_rise = n;
        if (!(u2 ? busy2 : busy1)) low_busy++;
        n++;
      end
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
        chk({e.tag, "_latency"}, 64'(n), 64'(e.lat));
        chk({e.tag, "_rdata"}, u2 ? rd2 : rd1, e.rd);
        chk({e.tag, "_first_rise"}, 64'(first_rise), 64'(exp_rise));
        chk({e.tag, "_busy_gap"}, 64'(low_busy), 64'd0);
        chk({e.tag, "_done_idle"}, u2 ? {busy2, sel2, mosi2} : {busy1, sel1, mosi1}, 64'd0);
      end
    end
  endtask

  // Entered at the negedge of the first cycle after iRst falls.
  task automatic resync_check(input string tag);
    int   busy_n, rises, sel_bad, done_bad;
    logic prev;
    busy_n = 0;
    rises = 0;
    sel_bad = 0;
    done_bad = 0;
    prev = 1'b0;
    for (int i = 0; i < 50 && busy1; i++) begin
      busy_n++;
      if (bclk1 && !prev) rises++;
      prev = bclk1;
      if (sel1 != 2'h0) sel_bad++;
      if (done1) done_bad++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd7);
    chk({tag, "_clock_pulses"}, 64'(rises), 64'd1);
    chk({tag, "_select_low"}, 64'(sel_bad), 64'd0);
    chk({tag, "_no_done"}, 64'(done_bad), 64'd0);
    chk({tag, "_idle_bus"}, {bclk1, sel1, mosi1, done1}, 64'd0);
  endtask

  logic [7:0] exp_mosi [6];

  initial begin
    exp_mosi = '{8'hEF, 8'hBE, 8'h34, 8'h81, 8'h00, 8'h00};
    rst = 1'b1;
    irq_i = 1'b0;
    start1 = 1'b0; write1 = 1'b0; addr1 = 15'h0; data1 = 16'h0;
    start2 = 1'b0; write2 = 1'b0; addr2 = 15'h0; data2 = 16'h0;
    miso2 = 8'hA5;
    mem[0] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy1, done1, rd1, irq_o1, bclk1, sel1, mosi1},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'h0, 8'h00});
    rst = 1'b0;
    resync_check("por");

    // Write 0x0134 <- BEEF; response comes from the model's reset address 0.
    drive1(1'b1, 15'h0134, 16'hBEEF);
    push_exp("wr_beef", 32'hDEADBEEF, 27);
    @(negedge clk);
    start1 = 1'b0;
    chk("wr_select_rise", {busy1, sel1}, {1'b1, Sel});
    wait_done(1'b0, 2, 3);
    for (int i = 0; i < 6; i++) chk($sformatf("wr_mosi_rise%0d", i + 1), mosi_log[i], exp_mosi[i]);
    chk("wr_commit", mem[8'h34], 32'h8134BEEF);

    // Double read: the first returns the previous address's word, the second the real one.
    drive1(1'b0, 15'h0100, 16'h0000);
    push_exp("rd1_first", 32'h8134BEEF, 27);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, 2, 3);
    drive1(1'b0, 15'h0100, 16'h0000);
    push_exp("rd1_second", 32'hDEADBEEF, 27);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, 2, 3);

    // iStart held high: ignored while busy, re-accepted in the oDone cycle.
    drive1(1'b0, 15'h0134, 16'h0000);
    push_exp("b2b_a", 32'hDEADBEEF, 27);
    @(negedge clk);
    chk("b2b_a_select", sel1, Sel);
    wait_done(1'b0, 2, 3);
    push_exp("b2b_b", 32'h8134BEEF, 27);
    @(negedge clk);
    chk("b2b_gap_one_cycle", {busy1, sel1}, {1'b1, Sel});
    start1 = 1'b0;
    wait_done(1'b0, 2, 3);

    // Reset after rise 3 aborts the write; the model keeps its previous address.
    drive1(1'b1, 15'h0055, 16'h1234);
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 100 && m_k < 3; i++) @(negedge clk);
    chk("abort_reached_rise3", 64'(m_k >= 3), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_select_drop", {sel1, busy1, done1, bclk1}, {2'h0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    resync_check("abort");
    drive1(1'b0, 15'h0100, 16'h0000);
    push_exp("post_abort_rd1", 32'h8134BEEF, 27);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, 2, 3);
    drive1(1'b0, 15'h0100, 16'h0000);
    push_exp("post_abort_rd2", 32'hDEADBEEF, 27);
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, 2, 3);

    // CLKDIV=1 instance with MISO tied to A5.
    @(negedge clk);
    start2 = 1'b1;
    addr2 = 15'h0022;
    push_exp("div1_rd", 32'hA5A5A5A5, 14);
    @(negedge clk);
    start2 = 1'b0;
    chk("div1_select_rise", {busy2, sel2}, {1'b1, Sel});
    wait_done(1'b1, 2, 2);

    // Interrupt synchronizer: two-cycle latency each direction.
    @(negedge clk);
    chk("irq_base", irq_o1, 1'b0);
    irq_i = 1'b1;
    @(negedge clk);
    chk("irq_rise_1cyc", irq_o1, 1'b0);
    @(negedge clk);
    chk("irq_rise_2cyc", irq_o1, 1'b1);
    irq_i = 1'b0;
    @(negedge clk);
    chk("irq_fall_1cyc", irq_o1, 1'b1);
    @(negedge clk);
    chk("irq_fall_2cyc", irq_o1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
